// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the SHA-256 config path
package sha256_pkg;

   localparam int SIZE_W = 64;
   localparam int ID_W   = 6;

   typedef enum logic [1:0] {
      SCHEME_SHA256 = 2'd0,
      SCHEME_SHA224 = 2'd1,
      SCHEME_RAW    = 2'd2,
      SCHEME_RSVD   = 2'd3
   } scheme_e;

   typedef struct packed {
      logic [SIZE_W-1:0] size;
      logic [1:0]        scheme;
   } cfg_t;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_e;

endpackage

// File: rtl/sha256_rr_picker.sv
// rtl/sha256_rr_picker.sv - round-robin pick of the first eligible index at or after rr_ptr
module sha256_rr_picker #(
   parameter int  N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  grant_oh,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   always_comb begin
      logic [IW-1:0] idx;
      idx       = '0;
      grant_oh  = '0;
      grant_idx = '0;
      any       = 1'b0;
      // N is a power of two, so the index wraps naturally
      for (int k = 0; k < N; k++) begin
         idx = rr_ptr + IW'(k);
         if (!any && eligible[idx]) begin
            any           = 1'b1;
            grant_idx     = idx;
            grant_oh[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sha256_cfg_arbiter.sv
// rtl/sha256_cfg_arbiter.sv - round-robin, batch-locked arbiter for the message builder cfg channel
module sha256_cfg_arbiter
   import sha256_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = sha256_pkg::ID_W,
   parameter int MAX_OUT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    sync_rst,
   input  logic [NUM_REQ*64-1:0]   req_cfg_size,
   input  logic [NUM_REQ*2-1:0]    req_cfg_scheme,
   input  logic [NUM_REQ-1:0]      req_cfg_last,
   input  logic [NUM_REQ-1:0]      req_cfg_valid,
   output logic [NUM_REQ-1:0]      req_cfg_ready,
   output logic [NUM_REQ*ID_W-1:0] req_id_next,
   output logic [63:0]             cfg_size,
   output logic [1:0]              cfg_scheme,
   output logic [ID_W-1:0]         cfg_id,
   output logic                    cfg_last,
   output logic                    cfg_valid,
   input  logic                    cfg_ready,
   input  logic [ID_W-1:0]         mon_id,
   input  logic                    mon_last,
   input  logic                    mon_valid,
   input  logic                    mon_ready,
   output logic                    err_underflow
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int SEQ_W = ID_W - IDX_W;
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [SEQ_W-1:0]   seq_q [NUM_REQ];
   logic [SEQ_W-1:0]   seq_d [NUM_REQ];
   logic [CNT_W-1:0]   out_q [NUM_REQ];
   logic [CNT_W-1:0]   out_d [NUM_REQ];
   cfg_t               cfg_q, cfg_d;
   logic [ID_W-1:0]    cfg_id_q, cfg_id_d;
   logic               cfg_last_q, cfg_last_d;
   logic               cfg_valid_q, cfg_valid_d;
   logic               err_q, err_d;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               slot_free;
   logic               accept;
   logic               complete;
   logic [IDX_W-1:0]   cmp_idx;
   logic               unused_mon_seq;

   assign unused_mon_seq = ^mon_id[SEQ_W-1:0];

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_cfg_valid[i] & (out_q[i] < MAX_CNT) & en;
      end
   end

   sha256_rr_picker #(.N(NUM_REQ)) u_picker (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr_q),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   always_comb begin
      state_d       = state_q;
      grant_idx_d   = grant_idx_q;
      grant_oh_d    = grant_oh_q;
      rr_ptr_d      = rr_ptr_q;
      seq_d         = seq_q;
      out_d         = out_q;
      cfg_d         = cfg_q;
      cfg_id_d      = cfg_id_q;
      cfg_last_d    = cfg_last_q;
      cfg_valid_d   = cfg_valid_q;
      err_d         = err_q;
      req_cfg_ready = '0;
      slot_free     = out_q[grant_idx_q] < MAX_CNT;
      complete      = mon_valid & mon_ready & mon_last;
      cmp_idx       = mon_id[ID_W-1 -: IDX_W];

      if (state_q == IDLE) begin
         if (pick_any) begin
            grant_idx_d = pick_idx;
            grant_oh_d  = pick_oh;
            state_d     = LOCK;
         end
      end else if (en && slot_free && (!cfg_valid_q || cfg_ready)) begin
         req_cfg_ready = grant_oh_q;
      end

      accept = |(req_cfg_valid & req_cfg_ready);

      if (accept) begin
         cfg_d.size   = req_cfg_size[grant_idx_q*SIZE_W +: SIZE_W];
         cfg_d.scheme = req_cfg_scheme[grant_idx_q*2 +: 2];
         cfg_last_d   = req_cfg_last[grant_idx_q];
         cfg_id_d     = {grant_idx_q, seq_q[grant_idx_q]};
         cfg_valid_d  = 1'b1;
         seq_d[grant_idx_q] = seq_q[grant_idx_q] + SEQ_W'(1);
         if (req_cfg_last[grant_idx_q]) begin
            rr_ptr_d = grant_idx_q + IDX_W'(1);
            state_d  = IDLE;
         end
      end else if (cfg_valid_q && cfg_ready) begin
         cfg_valid_d = 1'b0;
      end

      // an accept and a completion on the same requester cancel out
      for (int i = 0; i < NUM_REQ; i++) begin
         if ((accept && grant_idx_q == IDX_W'(i)) && !(complete && cmp_idx == IDX_W'(i))) begin
            out_d[i] = out_q[i] + CNT_W'(1);
         end else if ((complete && cmp_idx == IDX_W'(i)) && !(accept && grant_idx_q == IDX_W'(i))) begin
            if (out_q[i] == '0) begin
               err_d = 1'b1;
            end else begin
               out_d[i] = out_q[i] - CNT_W'(1);
            end
         end
      end

      if (sync_rst) begin
         state_d     = IDLE;
         grant_idx_d = '0;
         grant_oh_d  = '0;
         rr_ptr_d    = '0;
         cfg_d       = '0;
         cfg_id_d    = '0;
         cfg_last_d  = 1'b0;
         cfg_valid_d = 1'b0;
         err_d       = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            seq_d[i] = '0;
            out_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
         grant_oh_q  <= '0;
         rr_ptr_q    <= '0;
         cfg_q       <= '0;
         cfg_id_q    <= '0;
         cfg_last_q  <= 1'b0;
         cfg_valid_q <= 1'b0;
         err_q       <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            seq_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         grant_oh_q  <= grant_oh_d;
         rr_ptr_q    <= rr_ptr_d;
         cfg_q       <= cfg_d;
         cfg_id_q    <= cfg_id_d;
         cfg_last_q  <= cfg_last_d;
         cfg_valid_q <= cfg_valid_d;
         err_q       <= err_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            seq_q[i] <= seq_d[i];
            out_q[i] <= out_d[i];
         end
      end
   end

   always_comb begin
      req_id_next = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_id_next[i*ID_W +: ID_W] = {IDX_W'(i), seq_q[i]};
      end
   end

   assign cfg_size      = cfg_q.size;
   assign cfg_scheme    = cfg_q.scheme;
   assign cfg_id        = cfg_id_q;
   assign cfg_last      = cfg_last_q;
   assign cfg_valid     = cfg_valid_q;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_sha256_cfg_arbiter.sv
// tb/tb_sha256_cfg_arbiter.sv - scoreboard bench for sha256_cfg_arbiter
`timescale 1ns/1ps
module tb_sha256_cfg_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b1;
   logic           sync_rst = 1'b0;
   logic [N*64-1:0] req_cfg_size = '0;
   logic [N*2-1:0]  req_cfg_scheme = '0;
   logic [N-1:0]    req_cfg_last = '0;
   logic [N-1:0]    req_cfg_valid = '0;
   logic [N-1:0]    req_cfg_ready;
   logic [N*6-1:0]  req_id_next;
   logic [63:0]     cfg_size;
   logic [1:0]      cfg_scheme;
   logic [5:0]      cfg_id;
   logic            cfg_last;
   logic            cfg_valid;
   logic            cfg_ready = 1'b1;
   logic [5:0]      mon_id = '0;
   logic            mon_last = 1'b0;
   logic            mon_valid = 1'b0;
   logic            mon_ready = 1'b1;
   logic            err_underflow;

   always #5 clk = ~clk;

   sha256_cfg_arbiter dut (
      .clk(clk), .rst(rst), .en(en), .sync_rst(sync_rst),
      .req_cfg_size(req_cfg_size), .req_cfg_scheme(req_cfg_scheme),
      .req_cfg_last(req_cfg_last), .req_cfg_valid(req_cfg_valid),
      .req_cfg_ready(req_cfg_ready), .req_id_next(req_id_next),
      .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_id(cfg_id),
      .cfg_last(cfg_last), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .mon_id(mon_id), .mon_last(mon_last), .mon_valid(mon_valid),
      .mon_ready(mon_ready), .err_underflow(err_underflow)
   );

   typedef struct { logic [63:0] size; logic [1:0] scheme; logic last; } beat_t;
   typedef struct { logic [5:0] id; beat_t b; } exp_t;
   typedef struct { int req; logic last; logic [5:0] id; } vec_t;

   beat_t      rq [N][$];
   exp_t       exp_q [$];
   logic [5:0] cmp_q [$];
   bit         auto_cmp = 1'b0;
   int         hs_cnt = 0;
   int         beat_num = 0;
   int         n_pass = 0;
   int         n_checks = 0;

   vec_t t2 [6] = '{'{0, 1'b1, 6'h00}, '{2, 1'b1, 6'h20}, '{3, 1'b1, 6'h30},
                    '{0, 1'b1, 6'h01}, '{2, 1'b1, 6'h21}, '{3, 1'b1, 6'h31}};

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
      n_checks++;
      if (got !== req) $display("FAIL %s: got %0h required %0h", name, got, req);
      else n_pass++;
   endtask

   task automatic add_beat(input int req, input logic last, input logic [5:0] id, input bit expect_out = 1'b1);
      beat_t b;
      exp_t  e;
      beat_num++;
      b.size   = 64'hC0DE_0000_0000_0000 | 64'(beat_num);
      b.scheme = 2'(req + beat_num);
      b.last   = last;
      rq[req].push_back(b);
      if (expect_out) begin
         e.id = id;
         e.b  = b;
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0) begin
            req_cfg_valid[i]         = 1'b1;
            req_cfg_size[i*64 +: 64] = rq[i][0].size;
            req_cfg_scheme[i*2 +: 2] = rq[i][0].scheme;
            req_cfg_last[i]          = rq[i][0].last;
         end else begin
            req_cfg_valid[i] = 1'b0;
            req_cfg_last[i]  = 1'b0;
         end
      end
   endtask

   task automatic step();
      logic [N-1:0] acc;
      exp_t e;
      @(negedge clk);
      acc = req_cfg_valid & req_cfg_ready;
      if (cfg_valid && cfg_ready) begin
         hs_cnt++;
         if (auto_cmp) cmp_q.push_back(cfg_id);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL beat_unexpected: got id %0h, required no beat", cfg_id);
         end else begin
            e = exp_q.pop_front();
            check("beat", {cfg_id, cfg_scheme, cfg_last, cfg_size},
                  {e.id, e.b.scheme, e.b.last, e.b.size});
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i] && rq[i].size() > 0) rq[i].delete(0);
      drive_reqs();
      if (cmp_q.size() > 0) begin
         mon_valid = 1'b1;
         mon_last  = 1'b1;
         mon_id    = cmp_q.pop_front();
      end else begin
         mon_valid = 1'b0;
         mon_last  = 1'b0;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic clear_q();
      for (int i = 0; i < N; i++) rq[i].delete();
      exp_q.delete();
      cmp_q.delete();
   endtask

   task automatic do_sync_rst();
      clear_q();
      drive_reqs();
      sync_rst = 1'b1;
      step();
      sync_rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required $finish");
      $fatal(1);
   end

   initial begin
      logic [72:0] snap;
      bit stable, rdy_zero;
      int h0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_valid", cfg_valid, 0);
      check("rst_ready", req_cfg_ready, 0);
      check("rst_id_next", req_id_next, {6'h30, 6'h20, 6'h10, 6'h00});
      check("rst_err", err_underflow, 0);

      // async reset pulse while locked with a beat pending
      cfg_ready = 1'b0;
      add_beat(0, 1'b0, 6'h00, 1'b0);
      add_beat(0, 1'b1, 6'h01, 1'b0);
      drive_reqs();
      step();
      step();
      check("t1_pre_valid", cfg_valid, 1);
      check("t1_pre_id_next", req_id_next[5:0], 6'h01);
      #3 rst = 1'b1;
      @(negedge clk);
      check("t1_rst_out", {cfg_valid, cfg_last, cfg_scheme, cfg_id, cfg_size, req_cfg_ready, err_underflow}, 0);
      check("t1_rst_id_next", req_id_next, {6'h30, 6'h20, 6'h10, 6'h00});
      clear_q();
      drive_reqs();
      @(posedge clk);
      #1 rst = 1'b0;
      cfg_ready = 1'b1;

      // round-robin across requesters 0, 2, 3
      do_sync_rst();
      for (int k = 0; k < 6; k++) add_beat(t2[k].req, t2[k].last, t2[k].id);
      drive_reqs();
      drain(60);
      check("t2_id_next", req_id_next, {6'h32, 6'h22, 6'h10, 6'h02});

      // grant stays locked for a 3-beat batch while req0 waits
      do_sync_rst();
      for (int k = 0; k < 3; k++) add_beat(1, k == 2, 6'(6'h10 + k));
      drive_reqs();
      step();
      add_beat(0, 1'b1, 6'h00);
      drive_reqs();
      drain(40);

      // credit exhaustion mid-batch, released by one completion
      do_sync_rst();
      for (int k = 0; k < 5; k++) add_beat(2, k == 4, 6'(6'h20 + k));
      drive_reqs();
      repeat (12) step();
      check("t4_pending", exp_q.size(), 1);
      check("t4_ready_low", req_cfg_ready, 0);
      check("t4_beat_left", rq[2].size(), 1);
      cmp_q.push_back(6'h20);
      drain(20);

      // output backpressure then full-rate drain
      do_sync_rst();
      cfg_ready = 1'b0;
      for (int k = 0; k < 3; k++) add_beat(0, k == 2, 6'(k));
      drive_reqs();
      step();
      step();
      check("t5_valid", cfg_valid, 1);
      snap = {cfg_id, cfg_scheme, cfg_last, cfg_size};
      stable = 1'b1;
      rdy_zero = 1'b1;
      repeat (10) begin
         step();
         if ({cfg_id, cfg_scheme, cfg_last, cfg_size} !== snap || cfg_valid !== 1'b1) stable = 1'b0;
         if (req_cfg_ready !== '0) rdy_zero = 1'b0;
      end
      check("t5_stable", stable, 1);
      check("t5_ready_low", rdy_zero, 1);
      cfg_ready = 1'b1;
      h0 = hs_cnt;
      repeat (3) step();
      check("t5_full_rate", hs_cnt - h0, 3);
      check("t5_empty", exp_q.size(), 0);

      // sequence wrap, underflow, and counter left at zero
      do_sync_rst();
      auto_cmp = 1'b1;
      for (int k = 0; k < 17; k++) add_beat(3, 1'b1, 6'(6'h30 + (k % 16)));
      drive_reqs();
      drain(200);
      repeat (3) step();
      auto_cmp = 1'b0;
      check("t6_err_before", err_underflow, 0);
      cmp_q.push_back(6'h30);
      repeat (3) step();
      check("t6_err_set", err_underflow, 1);
      for (int k = 1; k <= 5; k++) add_beat(3, 1'b1, 6'(6'h30 + k), k < 5);
      drive_reqs();
      repeat (20) step();
      check("t6_four_accepted", exp_q.size(), 0);
      check("t6_fifth_blocked", rq[3].size(), 1);
      do_sync_rst();
      check("t6_err_cleared", err_underflow, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
